led_sequencer: RTL and testbench

Programmable pattern sequencer for the 7-bit user LED bank driven on io_out[18:12] of the user project. It accepts a configuration through a valid/ready handshake and steps an LED frame at a prescaled rate in one of four modes: static, binary count, rotate, bounce. A 16-phase PWM gate sets brightness. It drives both the LED data and the matching active-low output enables.

---
 rtl/led_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_led_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// Programmable LED pattern sequencer: static, count, rotate and bounce frames
// stepped by a prescaler, gated by a 16-phase PWM brightness control.
module led_sequencer #(
  parameter int               LED_W       = 7,
  parameter int               DIV_W       = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd999
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [LED_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_duty,
  output logic [LED_W-1:0] led_o,
  output logic [LED_W-1:0] led_oeb,
  output logic             step_o,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_STATIC = 2'd0,
    M_COUNT  = 2'd1,
    M_ROTATE = 2'd2,
    M_BOUNCE = 2'd3
  } mode_t;

  localparam logic [LED_W-1:0] LED_ONE  = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] LED_TOP  = {1'b1, {(LED_W-1){1'b0}}};
  localparam logic [LED_W-1:0] LED_ALL  = {LED_W{1'b1}};
  localparam logic [LED_W-1:0] LED_NONE = {LED_W{1'b0}};

  state_t             state;
  state_t             state_next;
  mode_t              mode_q;
  logic [DIV_W-1:0]   div_q;
  logic [LED_W-1:0]   pattern_q;
  logic [3:0]         duty_q;
  logic [LED_W-1:0]   frame;
  logic [DIV_W-1:0]   prescaler;
  logic [3:0]         phase;
  logic               dir_right;
  logic               configured;

  logic               accept;
  logic               due;
  logic               advance;
  logic               pwm_gate;
  logic [LED_W-1:0]   frame_adv;
  logic               dir_adv;

  // Config handshake: a transfer happens on a clock edge where cfg_valid and
  // cfg_ready are both high; the offerer holds its fields stable until then.
  // cfg_ready drops only for the single LOAD cycle.
  assign cfg_ready = (state != S_LOAD);
  assign dbg_state = state;
  assign pwm_gate  = (duty_q == 4'hF) || (phase < duty_q);

  always_comb begin
    state_next = state;
    accept     = cfg_valid && cfg_ready;
    due        = (state == S_RUN) && (prescaler == div_q);
    advance    = due && !accept;
    frame_adv  = frame;
    dir_adv    = dir_right;

    case (mode_q)
      M_STATIC: frame_adv = frame;
      M_COUNT:  frame_adv = frame + LED_ONE;
      M_ROTATE: frame_adv = {frame[LED_W-2:0], frame[LED_W-1]};
      M_BOUNCE: begin
        // End bits reverse the direction so each end is shown for one step.
        if (!dir_right) begin
          if (frame[LED_W-1]) begin
            frame_adv = frame >> 1;
            dir_adv   = 1'b1;
          end else begin
            frame_adv = frame << 1;
          end
        end else begin
          if (frame[0]) begin
            frame_adv = frame << 1;
            dir_adv   = 1'b0;
          end else begin
            frame_adv = frame >> 1;
          end
        end
      end
      default: frame_adv = frame;
    endcase

    case (state)
      S_IDLE: begin
        if (accept)      state_next = S_LOAD;
        else if (enable) state_next = S_RUN;
      end
      S_LOAD: begin
        state_next = enable ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (accept)       state_next = S_LOAD;
        else if (!enable) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      mode_q     <= M_STATIC;
      div_q      <= DEFAULT_DIV;
      pattern_q  <= LED_NONE;
      duty_q     <= 4'hF;
      configured <= 1'b0;
    end else if (accept) begin
      mode_q     <= mode_t'(cfg_mode);
      div_q      <= cfg_div;
      pattern_q  <= cfg_pattern;
      duty_q     <= cfg_duty;
      configured <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      frame     <= LED_NONE;
      prescaler <= '0;
      dir_right <= 1'b0;
      phase     <= 4'd0;
    end else begin
      phase <= phase + 4'd1;
      case (state)
        S_LOAD: begin
          frame     <= (mode_q == M_BOUNCE) ? LED_ONE : pattern_q;
          dir_right <= 1'b0;
          prescaler <= '0;
        end
        S_RUN: begin
          if (advance) begin
            frame     <= frame_adv;
            dir_right <= dir_adv;
            prescaler <= '0;
          end else if (!accept) begin
            prescaler <= prescaler + 1'b1;
          end
        end
        default: begin
          frame     <= frame;
          prescaler <= prescaler;
        end
      endcase
    end
  end

  // Outputs are registered images of the pre-edge state, frame and PWM phase.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      led_o   <= LED_NONE;
      led_oeb <= LED_ALL;
      step_o  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      led_o   <= (state == S_RUN) ? (frame & {LED_W{pwm_gate}}) : LED_NONE;
      led_oeb <= configured ? LED_NONE : LED_ALL;
      step_o  <= advance;
      busy    <= (state == S_RUN);
    end
  end

  logic unused_top;
  assign unused_top = ^LED_TOP;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: behavioural model compared every cycle, plus
// directed scenarios with literal expectations and a randomized soak.
module tb_led_sequencer;
  localparam int LW = 7;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_mode = 2'd0;
  logic [DW-1:0] cfg_div = '0;
  logic [LW-1:0] cfg_pattern = '0;
  logic [3:0]    cfg_duty = 4'd0;
  logic [LW-1:0] led_o;
  logic [LW-1:0] led_oeb;
  logic          step_o;
  logic          busy;
  logic [1:0]    dbg_state;

  led_sequencer #(.LED_W(LW), .DIV_W(DW), .DEFAULT_DIV(16'd999)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
    .cfg_div(cfg_div), .cfg_pattern(cfg_pattern), .cfg_duty(cfg_duty),
    .led_o(led_o), .led_oeb(led_oeb), .step_o(step_o), .busy(busy),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  // Behavioural model: whole-frame arithmetic, a "loading" flag for the
  // one-cycle config load and a "running" flag for the enable gate.
  int m_led = 0, m_oeb = 127, m_step = 0, m_busy = 0, m_ready = 1, m_acc = 0;
  int m_loading = 0, m_running = 0, m_cfgd = 0;
  int m_mode = 0, m_div = 999, m_pat = 0, m_duty = 15;
  int m_frame = 0, m_cnt = 0, m_dir = 1, m_phase = 0;
  int m_gate, m_due;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_led = 0; m_oeb = 127; m_step = 0; m_busy = 0; m_ready = 1; m_acc = 0;
      m_loading = 0; m_running = 0; m_cfgd = 0;
      m_mode = 0; m_div = 999; m_pat = 0; m_duty = 15;
      m_frame = 0; m_cnt = 0; m_dir = 1; m_phase = 0;
    end else begin
      m_acc  = (cfg_valid && !m_loading) ? 1 : 0;
      m_gate = (m_duty == 15 || m_phase < m_duty) ? 1 : 0;
      m_busy = (m_running && !m_loading) ? 1 : 0;
      m_led  = (m_busy && m_gate) ? m_frame : 0;
      m_oeb  = m_cfgd ? 0 : 127;
      m_due  = (m_busy && m_cnt == m_div) ? 1 : 0;
      m_step = (m_due && !m_acc) ? 1 : 0;
      m_phase = (m_phase + 1) % 16;
      if (m_loading) begin
        m_frame = (m_mode == 3) ? 1 : m_pat;
        m_dir = 1; m_cnt = 0; m_loading = 0;
        m_running = enable ? 1 : 0;
      end else if (m_acc) begin
        m_mode = int'(cfg_mode); m_div = int'(cfg_div);
        m_pat = int'(cfg_pattern); m_duty = int'(cfg_duty);
        m_cfgd = 1; m_loading = 1;
      end else if (m_running) begin
        if (m_due) begin
          m_cnt = 0;
          case (m_mode)
            1: m_frame = (m_frame + 1) % 128;
            2: m_frame = ((m_frame * 2) % 128) + (m_frame / 64);
            3: begin
              if (m_dir > 0) begin
                if (m_frame == 64) begin m_frame = 32; m_dir = -1; end
                else m_frame = m_frame * 2;
              end else begin
                if (m_frame == 1) begin m_frame = 2; m_dir = 1; end
                else m_frame = m_frame / 2;
              end
            end
            default: m_frame = m_frame;
          endcase
        end else begin
          m_cnt++;
        end
        if (!enable) m_running = 0;
      end else if (enable) begin
        m_running = 1;
      end
      m_ready = m_loading ? 0 : 1;
    end
  end

  always @(negedge clk) begin
    check("led_o", int'(led_o), m_led);
    check("led_oeb", int'(led_oeb), m_oeb);
    check("step_o", int'(step_o), m_step);
    check("busy", int'(busy), m_busy);
    check("cfg_ready", int'(cfg_ready), m_ready);
  end

  task automatic drive_cfg(input int mode, input int div, input int pat, input int duty);
    int done;
    done = 0;
    @(posedge clk); #1;
    cfg_mode = 2'(mode); cfg_div = DW'(div); cfg_pattern = LW'(pat); cfg_duty = 4'(duty);
    cfg_valid = 1'b1;
    for (int i = 0; i < 4 && done == 0; i++) begin
      @(posedge clk); #1;
      if (m_acc != 0) done = 1;
    end
    cfg_valid = 1'b0;
    check("cfg_accept", done, 1);
  endtask

  task automatic wait_step(output int val, output int cyc);
    int found;
    found = 0; val = -1; cyc = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (step_o) begin found = 1; val = int'(led_o); cyc = cycle; end
    end
    check("step_seen", found, 1);
  endtask

  task automatic count_on(input string name, input int exp_on);
    int on, bad;
    on = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (led_o == 7'h7F) on++;
      else if (led_o != 7'h00) bad++;
    end
    check(name, on, exp_on);
    check("pwm_levels", bad, 0);
  endtask

  int exp_cnt[5]     = '{'h7D, 'h7E, 'h7F, 'h00, 'h01};
  int exp_bounce[14] = '{1, 2, 4, 8, 16, 32, 64, 32, 16, 8, 4, 2, 1, 2};

  initial begin
    int v, c, pc;
    repeat (3) @(negedge clk);
    check("rst_led", int'(led_o), 0);
    check("rst_oeb", int'(led_oeb), 'h7F);
    check("rst_ready", int'(cfg_ready), 1);
    check("rst_busy", int'(busy), 0);
    #1 rst = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_cfg_oeb", int'(led_oeb), 'h7F);

    // COUNT wraps through 7F -> 00 with a step every div+1 clocks
    drive_cfg(1, 3, 'h7D, 15);
    pc = 0;
    for (int i = 0; i < 5; i++) begin
      wait_step(v, c);
      check("count_seq", v, exp_cnt[i]);
      if (i > 0) check("count_gap", c - pc, 4);
      pc = c;
    end
    check("cfg_oeb", int'(led_oeb), 0);

    // BOUNCE at full speed
    drive_cfg(3, 0, 'h55, 15);
    for (int i = 0; i < 14; i++) begin
      wait_step(v, c);
      check("bounce_seq", v, exp_bounce[i]);
      if (i > 0) check("bounce_gap", c - pc, 1);
      pc = c;
    end

    // ROTATE with an enable gap after the frame reaches 03
    drive_cfg(2, 1, 'h41, 15);
    wait_step(v, c);
    check("rot_first", v, 'h41);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check("rot_idle_led", int'(led_o), 0);
        check("rot_idle_busy", int'(busy), 0);
      end
    end
    enable = 1'b1;
    wait_step(v, c);
    check("rot_resume_step", v, 'h03);
    @(negedge clk);
    check("rot_resume_led", int'(led_o), 'h06);

    // PWM brightness
    drive_cfg(0, 7, 'h7F, 4);
    repeat (4) @(negedge clk);
    count_on("pwm_duty4", 4);
    drive_cfg(0, 7, 'h7F, 0);
    repeat (4) @(negedge clk);
    count_on("pwm_duty0", 0);
    drive_cfg(0, 7, 'h7F, 15);
    repeat (4) @(negedge clk);
    count_on("pwm_duty15", 16);

    // Config landing on the edge where an advance is due
    drive_cfg(1, 5, 'h10, 15);
    wait_step(v, c);
    check("due_first", v, 'h10);
    repeat (5) @(posedge clk);
    #1;
    cfg_mode = 2'd0; cfg_div = DW'(5); cfg_pattern = 7'h2A; cfg_duty = 4'd15;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    check("due_no_step", int'(step_o), 0);
    check("due_ready_low", int'(cfg_ready), 0);
    @(negedge clk);
    check("due_ready_back", int'(cfg_ready), 1);
    @(negedge clk);
    check("due_new_pattern", int'(led_o), 'h2A);

    // Config accepted while enable is low parks in IDLE
    enable = 1'b0;
    repeat (3) @(negedge clk);
    drive_cfg(2, 2, 'h15, 15);
    repeat (4) @(negedge clk);
    check("park_busy", int'(busy), 0);
    check("park_led", int'(led_o), 0);
    enable = 1'b1;
    wait_step(v, c);
    check("park_resume", v, 'h15);

    // Asynchronous reset in the middle of a cycle
    repeat (3) @(negedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_led", int'(led_o), 0);
    check("arst_oeb", int'(led_oeb), 'h7F);
    check("arst_ready", int'(cfg_ready), 1);
    check("arst_busy", int'(busy), 0);
    check("arst_step", int'(step_o), 0);
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_oeb_hold", int'(led_oeb), 'h7F);

    // Randomized soak: valid held until accepted, enable toggles
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (cfg_valid && m_acc != 0) cfg_valid = 1'b0;
      if (!cfg_valid && $urandom_range(0, 39) == 0) begin
        cfg_mode    = 2'($urandom_range(0, 3));
        cfg_div     = DW'($urandom_range(0, 6));
        cfg_pattern = LW'($urandom_range(0, 127));
        cfg_duty    = 4'($urandom_range(0, 15));
        cfg_valid   = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) enable = ~enable;
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
